// File: rtl/hue_calc_if.sv
// Pixel-in / result-out handshake bundle for hue_calc.
// The master drives pixels and out_ready; the slave (hue_calc) returns results.
interface hue_calc_if #(
  parameter int W = 10
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] red;
  logic [W-1:0] green;
  logic [W-1:0] blue;
  logic [W-1:0] min_value;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   hue;
  logic [W-1:0] max_value;
  logic [W-1:0] chroma;
  logic [8:0]   sat;

  modport master (
    output in_valid, red, green, blue, min_value, out_ready,
    input  in_ready, out_valid, hue, max_value, chroma, sat
  );

  modport slave (
    input  in_valid, red, green, blue, min_value, out_ready,
    output in_ready, out_valid, hue, max_value, chroma, sat
  );
endinterface

// File: rtl/hue_calc.sv
// Per-pixel max, chroma and hue (0..1535) via a shared iterative restoring divider.
// Define HUE_CALC_SAT_EN to add the SDIV pass that computes sat = delta*256/max.
module hue_calc #(
  parameter int W    = 10,
  parameter int FRAC = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      ce,
  hue_calc_if.slave bus
);
  localparam int QW = FRAC + 1;
  localparam int CW = $clog2(QW);
  localparam logic [W:0] HUE_G    = (W+1)'(2 << FRAC);
  localparam logic [W:0] HUE_B    = (W+1)'(4 << FRAC);
  localparam logic [W:0] HUE_WRAP = (W+1)'(6 << FRAC);

`ifdef HUE_CALC_SAT_EN
  typedef enum logic [1:0] {IDLE, DIV, SDIV, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
`endif

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic [W:0]      rem_reg;
  logic [QW-1:0]   quo_reg;
  logic [1:0]      idx_reg;
  logic            d_neg_reg;
  logic [W:0]      hue_reg;
  logic [W-1:0]    max_reg;
  logic [W-1:0]    chroma_reg;

  logic [W-1:0]    max_in;
  logic [W-1:0]    delta_in;
  logic [1:0]      idx_in;
  logic signed [W:0] d_in;
  logic [W-1:0]    abs_d;

  // Max selection with R>G>B tie priority; d is the sector-relative difference.
  always_comb begin
    max_in = bus.red;
    idx_in = 2'd0;
    d_in   = $signed({1'b0, bus.green}) - $signed({1'b0, bus.blue});
    if (!(bus.red >= bus.green && bus.red >= bus.blue)) begin
      if (bus.green >= bus.blue) begin
        max_in = bus.green;
        idx_in = 2'd1;
        d_in   = $signed({1'b0, bus.blue}) - $signed({1'b0, bus.red});
      end else begin
        max_in = bus.blue;
        idx_in = 2'd2;
        d_in   = $signed({1'b0, bus.red}) - $signed({1'b0, bus.green});
      end
    end
    delta_in = (bus.min_value > max_in) ? '0 : max_in - bus.min_value;
    abs_d    = d_in[W] ? W'(-d_in) : d_in[W-1:0];
  end

  logic [W-1:0]  divisor;
  logic          take;
  logic [W:0]    rem_sub;
  logic [W:0]    rem_shift;
  logic [QW-1:0] quo_next;
  logic [W:0]    q_ext;
  logic [W:0]    hue_form;

  // The remainder starts at the numerator's integer part and shifts in zeros,
  // which yields floor(num*256/div) as long as num <= div.
  always_comb begin
    divisor = chroma_reg;
`ifdef HUE_CALC_SAT_EN
    if (state_reg == SDIV) divisor = max_reg;
`endif
    take      = rem_reg >= {1'b0, divisor};
    rem_sub   = take ? rem_reg - {1'b0, divisor} : rem_reg;
    rem_shift = rem_sub << 1;
    quo_next  = {quo_reg[QW-2:0], take};
    q_ext     = (W+1)'(quo_next);
    case (idx_reg)
      2'd0:    hue_form = !d_neg_reg ? q_ext : ((quo_next == '0) ? '0 : HUE_WRAP - q_ext);
      2'd1:    hue_form = d_neg_reg ? HUE_G - q_ext : HUE_G + q_ext;
      default: hue_form = d_neg_reg ? HUE_B - q_ext : HUE_B + q_ext;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else if (ce) state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = (delta_in == '0) ? DONE : DIV;
      end
      DIV: begin
`ifdef HUE_CALC_SAT_EN
        if (cnt_reg == '0) state_next = SDIV;
`else
        if (cnt_reg == '0) state_next = DONE;
`endif
      end
`ifdef HUE_CALC_SAT_EN
      SDIV: if (cnt_reg == '0) state_next = DONE;
`endif
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef HUE_CALC_SAT_EN
  logic [QW-1:0] sat_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      idx_reg    <= '0;
      d_neg_reg  <= 1'b0;
      hue_reg    <= '0;
      max_reg    <= '0;
      chroma_reg <= '0;
`ifdef HUE_CALC_SAT_EN
      sat_reg    <= '0;
`endif
    end else if (ce) begin
      case (state_reg)
        IDLE: if (bus.in_valid) begin
          max_reg    <= max_in;
          chroma_reg <= delta_in;
          idx_reg    <= idx_in;
          d_neg_reg  <= d_in[W];
          rem_reg    <= {1'b0, abs_d};
          quo_reg    <= '0;
          cnt_reg    <= CW'(FRAC);
          if (delta_in == '0) begin
            hue_reg <= '0;
`ifdef HUE_CALC_SAT_EN
            sat_reg <= '0;
`endif
          end
        end
        DIV: begin
          rem_reg <= rem_shift;
          quo_reg <= quo_next;
          if (cnt_reg == '0) begin
            hue_reg <= hue_form;
`ifdef HUE_CALC_SAT_EN
            rem_reg <= {1'b0, chroma_reg};
            quo_reg <= '0;
            cnt_reg <= CW'(FRAC);
`endif
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
`ifdef HUE_CALC_SAT_EN
        SDIV: begin
          rem_reg <= rem_shift;
          quo_reg <= quo_next;
          if (cnt_reg == '0) sat_reg <= quo_next;
          else cnt_reg <= cnt_reg - 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.hue       = hue_reg;
  assign bus.max_value = max_reg;
  assign bus.chroma    = chroma_reg;
`ifdef HUE_CALC_SAT_EN
  assign bus.sat       = sat_reg;
`else
  assign bus.sat       = '0;
`endif
endmodule

// File: tb/tb_hue_calc.sv
// Scoreboard bench for hue_calc: driver pushes model results, monitor pops on each result.
// Reference model works from plain max/min/modular-hue arithmetic.
module tb_hue_calc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b1;

  hue_calc_if bus();
  hue_calc dut (.clk(clk), .rst(rst), .ce(ce), .bus(bus));

  always #5 clk = ~clk;

`ifdef HUE_CALC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {int hue; int mx; int chroma; int sat; int lat; int acc;} exp_t;
  exp_t sb[$];

  int compared = 0, mismatched = 0, ce_cycles = 0, npix = 0;
  int ce_mode = 0, rdy_mode = 0;

  always @(posedge clk) if (ce) ce_cycles <= ce_cycles + 1;

  task automatic check(string name, int got, int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic exp_t model(int r, int g, int b, int mn);
    exp_t e;
    int mx, d, base, q;
    if (r >= g && r >= b) begin mx = r; d = g - b; base = 0;    end
    else if (g >= b)      begin mx = g; d = b - r; base = 512;  end
    else                  begin mx = b; d = r - g; base = 1024; end
    e.mx = mx;
    e.chroma = (mn > mx) ? 0 : mx - mn;
    e.acc = 0;
    if (e.chroma == 0) begin
      e.hue = 0; e.sat = 0; e.lat = 1;
    end else begin
      q = ((d < 0 ? -d : d) * 256) / e.chroma;
      e.hue = (base + (d < 0 ? -q : q) + 1536) % 1536;
      e.sat = SAT ? (e.chroma * 256) / mx : 0;
      e.lat = SAT ? 19 : 10;
    end
    return e;
  endfunction

  initial forever begin
    @(negedge clk);
    case (ce_mode)
      0:       ce = 1'b1;
      1:       ce = ($urandom_range(3) != 0);
      default: ce = 1'b0;
    endcase
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(2) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  task automatic send(int r, int g, int b, int mn);
    exp_t e;
    int n = 0;
    bit done = 0;
    e = model(r, g, b, mn);
    @(negedge clk);
    bus.red = 10'(r); bus.green = 10'(g); bus.blue = 10'(b); bus.min_value = 10'(mn);
    bus.in_valid = 1'b1;
    while (!done) begin
      #1;
      if (ce && bus.in_ready && !rst) begin
        e.acc = ce_cycles;
        sb.push_back(e);
        done = 1;
      end else if (++n > 500) begin
        compared++; mismatched++;
        $display("FAIL accept_timeout: in_ready never seen in 500 cycles, expected accept");
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.red = 10'($urandom); bus.green = 10'($urandom); bus.blue = 10'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      compared++; mismatched++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: latency on rising out_valid, data every valid cycle, pop on consume.
  initial begin
    bit prev = 0;
    forever begin
      @(negedge clk); #1;
      if (rst) prev = 0;
      else if (bus.out_valid) begin
        if (sb.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL spurious_out_valid: got 1, expected 0 (no pixel pending)");
        end else begin
          if (!prev) check("latency", ce_cycles - sb[0].acc, sb[0].lat);
          check("hue", int'(bus.hue), sb[0].hue);
          check("max_value", int'(bus.max_value), sb[0].mx);
          check("chroma", int'(bus.chroma), sb[0].chroma);
          check("sat", int'(bus.sat), sb[0].sat);
          check("in_ready_in_done", int'(bus.in_ready), 0);
          if (ce && bus.out_ready) begin
            $display("pix %0d: hue=%0d max=%0d chroma=%0d sat=%0d (expected %0d/%0d/%0d/%0d)",
                     npix, bus.hue, bus.max_value, bus.chroma, bus.sat,
                     sb[0].hue, sb[0].mx, sb[0].chroma, sb[0].sat);
            void'(sb.pop_front());
            npix++;
          end
        end
        prev = 1;
      end else prev = 0;
    end
  end

  initial begin
    int r, g, b, mn, mx, tmin, k, n;
    bus.in_valid = 1'b0;
    bus.red = '0; bus.green = '0; bus.blue = '0; bus.min_value = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_hue", int'(bus.hue), 0);
    check("rst_max_value", int'(bus.max_value), 0);
    check("rst_chroma", int'(bus.chroma), 0);
    check("rst_sat", int'(bus.sat), 0);
    @(negedge clk); rst = 1'b0;

    // Directed pixels, including q=256 boundaries and min above max.
    send(800, 400, 200, 200);
    send(100, 300, 500, 100);
    send(600, 100, 350, 100);
    send(512, 512, 512, 512);
    send(500, 100, 500, 100);
    send(500, 500, 100, 100);
    send(100, 100, 100, 200);
    send(300, 200, 250, 50);
    drain();

    // Downstream stall for several cycles.
    rdy_mode = 2;
    send(800, 400, 200, 200);
    n = 0;
    while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    rdy_mode = 0;
    send(100, 300, 500, 100);
    drain();

    // Clock-enable gap during DIV.
    send(800, 400, 200, 200);
    repeat (3) @(negedge clk);
    ce_mode = 2;
    repeat (4) @(negedge clk);
    ce_mode = 0;
    drain();

    // Reset mid-division aborts the pixel.
    send(800, 400, 200, 200);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    check("abort_in_ready", int'(bus.in_ready), 1);
    check("abort_out_valid", int'(bus.out_valid), 0);
    @(negedge clk); rst = 1'b0;
    #1;
    check("post_rst_in_ready", int'(bus.in_ready), 1);
    send(100, 300, 500, 100);
    drain();

    // Randomized pixels with random ce and out_ready.
    ce_mode = 1; rdy_mode = 1;
    repeat (150) begin
      r = $urandom_range(1023); g = $urandom_range(1023); b = $urandom_range(1023);
      k = $urandom_range(9);
      if (k == 9) begin g = r; b = r; end
      tmin = (r < g) ? r : g; tmin = (b < tmin) ? b : tmin;
      mx = (r > g) ? r : g;   mx = (b > mx) ? b : mx;
      if (k == 7) mn = $urandom_range(tmin, 0);
      else if (k == 8 && mx < 1023) mn = $urandom_range(1023, mx + 1);
      else mn = tmin;
      send(r, g, b, mn);
    end
    drain();
    ce_mode = 0; rdy_mode = 0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
